// File: rtl/exu_muldiv_pkg.sv
// Shared types and width-derived constants for the multi-cycle multiply/divide unit.
package exu_muldiv_pkg;

  // funct3 encodings of the M-extension ops
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } muldiv_state_e;

  localparam int unsigned MaxXlen = 64;

  // Most-negative two's-complement value of an xlen-bit word, right-aligned.
  function automatic logic [MaxXlen-1:0] most_neg(input int unsigned xlen);
    return {1'b1, {(MaxXlen-1){1'b0}}} >> (MaxXlen - xlen);
  endfunction

  function automatic logic [MaxXlen-1:0] all_ones(input int unsigned xlen);
    return {MaxXlen{1'b1}} >> (MaxXlen - xlen);
  endfunction

  function automatic logic op_src1_signed(input muldiv_op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op_src2_signed(input muldiv_op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/exu_muldiv_iter.sv
// Per-cycle shift-add / restoring-subtract step over unsigned magnitudes.
// EXU_MULDIV_FAST_MUL_EN: multiplies finish in one step with a combinational multiplier.
module exu_muldiv_iter
  import exu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic [2*XLEN-1:0] acc_next,
  output logic              last
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   b_q;
  logic [CntW-1:0]   cnt_q;
  logic [CntW-1:0]   cnt_load;
  logic              div_q;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] acc_step;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_shift = acc_q[2*XLEN-1:XLEN-1];
    div_trial = rem_shift - {1'b0, b_q};
    if (div_q) begin
      // A borrow out of the trial subtract means the divisor did not fit: restore.
      if (div_trial[XLEN]) begin
        acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end else begin
        acc_step = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

`ifdef EXU_MULDIV_FAST_MUL_EN
  assign acc_next = div_q ? acc_step
                          : {{XLEN{1'b0}}, acc_q[XLEN-1:0]} * {{XLEN{1'b0}}, b_q};
  assign cnt_load = is_div ? CntW'(XLEN) : CntW'(1);
`else
  assign acc_next = acc_step;
  assign cnt_load = CntW'(XLEN);
`endif

  assign last = (cnt_q == CntW'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      acc_q <= {{XLEN{1'b0}}, op_a};
      b_q   <= op_b;
      cnt_q <= cnt_load;
      div_q <= is_div;
    end else if (step) begin
      acc_q <= acc_next;
      cnt_q <= cnt_q - CntW'(1);
    end
  end

endmodule

// File: rtl/exu_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit: FSM, handshakes, special cases, sign fix-up.
// Optional EXU_MULDIV_FAST_MUL_EN selects a single-cycle multiply step in exu_muldiv_iter.
module exu_muldiv
  import exu_muldiv_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [XLEN-1:0]  in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam logic [MaxXlen-1:0] MostNegFull = most_neg(XLEN);
  localparam logic [MaxXlen-1:0] AllOnesFull = all_ones(XLEN);
  localparam logic [XLEN-1:0]    MostNeg     = MostNegFull[XLEN-1:0];
  localparam logic [XLEN-1:0]    AllOnes     = AllOnesFull[XLEN-1:0];

  muldiv_state_e    state_q, state_d;
  muldiv_op_e       op_q;
  muldiv_op_e       op_in;
  logic             neg_q, neg_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q;

  logic             accept;
  logic             load;
  logic             step;
  logic             last;
  logic             s1_neg, s2_neg;
  logic             div_by_zero, overflow, special;
  logic [XLEN-1:0]  mag_a, mag_b;
  logic [XLEN-1:0]  special_res;
  logic [XLEN-1:0]  fixed_res;
  logic [2*XLEN-1:0] acc_next;
  logic [2*XLEN-1:0] acc_neg;

  assign op_in = muldiv_op_e'(in_op);

  always_comb begin
    s1_neg      = op_src1_signed(op_in) && in_src1[XLEN-1];
    s2_neg      = op_src2_signed(op_in) && in_src2[XLEN-1];
    mag_a       = s1_neg ? -in_src1 : in_src1;
    mag_b       = s2_neg ? -in_src2 : in_src2;
    // Remainder follows the dividend; everything else follows the sign product.
    neg_d       = (op_in == OpRem) ? s1_neg : (s1_neg ^ s2_neg);
    div_by_zero = in_op[2] && (in_src2 == '0);
    overflow    = (op_in inside {OpDiv, OpRem}) && (in_src1 == MostNeg) && (in_src2 == AllOnes);
    special     = div_by_zero || overflow;
    if (div_by_zero) begin
      special_res = in_op[1] ? in_src1 : AllOnes;
    end else begin
      special_res = in_op[1] ? '0 : in_src1;
    end
  end

  // Multiplies negate the full 2*XLEN product so the high half carries correctly.
  always_comb begin
    acc_neg = -acc_next;
    case (op_q)
      OpMul:                     fixed_res = neg_q ? acc_neg[XLEN-1:0] : acc_next[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: fixed_res = neg_q ? acc_neg[2*XLEN-1:XLEN]
                                                   : acc_next[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             fixed_res = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
      default:                   fixed_res = neg_q ? -acc_next[2*XLEN-1:XLEN]
                                                   : acc_next[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    accept   = in_valid && (state_q == StIdle) && !flush;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (special) begin
            state_d  = StDone;
            result_d = special_res;
          end else begin
            state_d = StBusy;
            load    = 1'b1;
          end
        end
      end
      StBusy: begin
        step = 1'b1;
        if (last) begin
          state_d  = StDone;
          result_d = fixed_res;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      neg_q    <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        op_q  <= op_in;
        neg_q <= neg_d;
        tag_q <= in_tag;
      end
    end
  end

  exu_muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .is_div   (in_op[2]),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .acc_next (acc_next),
    .last     (last)
  );

  assign in_ready   = (state_q == StIdle);
  assign out_valid  = (state_q == StDone);
  assign busy       = (state_q != StIdle);
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// Randomized and directed checks of exu_muldiv against a plain-arithmetic RV32M model.
module tb_exu_muldiv;
  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 5;
`ifdef EXU_MULDIV_FAST_MUL_EN
  localparam int MulLat = 2;
`else
  localparam int MulLat = XLEN + 1;
`endif

  logic             clk, rst, flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]       in_op;
  logic [31:0]      in_src1, in_src2, out_result;
  logic [4:0]       in_tag, out_tag;

  exu_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rand_en = 0;

  // model of the unit: one outstanding op, ready at a known cycle
  bit          m_pending = 0;
  int          m_valid_at = 0;
  logic [31:0] m_result = '0;
  logic [4:0]  m_tag = '0;
  logic        exp_valid;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    bit ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op >= 3'd4 && b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return (op < 3'd4) ? MulLat : XLEN + 1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 0;
    end else if (flush) begin
      m_pending <= 0;
    end else if (m_pending && cyc >= m_valid_at && out_ready) begin
      m_pending <= 0;
    end else if (!m_pending && in_valid) begin
      m_pending  <= 1;
      m_valid_at <= cyc + ref_lat(in_op, in_src1, in_src2);
      m_result   <= ref_result(in_op, in_src1, in_src2);
      m_tag      <= in_tag;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      exp_valid = m_pending && (cyc >= m_valid_at);
      chk("in_ready", in_ready, !m_pending);
      chk("busy", busy, m_pending);
      chk("out_valid", out_valid, exp_valid);
      if (exp_valid) begin
        chk("out_result", out_result, m_result);
        chk("out_tag", out_tag, m_tag);
      end
    end
  end

  always @(negedge clk) begin
    if (rand_en) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 63) == 0);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("issue_wait_in_ready", in_ready, 1'b1);
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    in_tag   = tag;
    last_acc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output logic [31:0] res, output logic [4:0] tg, output int at);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("wait_out_valid", out_valid, 1'b1);
    res = out_result;
    tg  = out_tag;
    at  = cyc;
  endtask

  task automatic directed(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp,
                          input int exp_lat);
    logic [31:0] res;
    logic [4:0]  tg;
    int at, c0;
    chk({name, "_model"}, ref_result(op, a, b), exp);
    out_ready = 1'b1;
    issue(op, a, b, tag);
    c0 = last_acc;
    wait_valid(res, tg, at);
    chk(name, res, exp);
    chk({name, "_tag"}, tg, tag);
    chk({name, "_latency"}, at - c0, exp_lat);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] res0;
    logic [4:0]  tg0;
    int at0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_src1 = '0; in_src2 = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_out_result", out_result, 32'h0);
    chk("reset_out_tag", out_tag, 5'h0);
    rst = 1'b0;
    @(negedge clk);

    directed("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, MulLat);
    directed("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'hFFFF_FFFE, MulLat);
    directed("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'h0, MulLat);
    directed("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF, MulLat);
    directed("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD, XLEN + 1);
    directed("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF, XLEN + 1);
    directed("divu_100_7", 3'd5, 32'd100, 32'd7, 5'd6, 32'd14, XLEN + 1);
    directed("remu_100_7", 3'd7, 32'd100, 32'd7, 5'd7, 32'd2, XLEN + 1);
    directed("divu_by0", 3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF, 1);
    directed("remu_by0", 3'd7, 32'd5, 32'd0, 5'd10, 32'd5, 1);
    directed("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1);
    directed("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1);

    // backpressure: result must sit still while the consumer stalls
    out_ready = 1'b0;
    issue(3'd0, 32'd1234, 32'd5678, 5'd21);
    wait_valid(res0, tg0, at0);
    chk("bp_result", res0, 32'd7006652);
    repeat (10) begin
      @(negedge clk);
      chk("bp_hold_result", out_result, 32'd7006652);
      chk("bp_hold_tag", out_tag, 5'd21);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_after_drain", in_ready, 1'b1);
    directed("bp_next_op", 3'd5, 32'd81, 32'd9, 5'd22, 32'd9, XLEN + 1);

    // flush in the 10th BUSY cycle
    issue(3'd0, 32'd3, 32'd4, 5'd13);
    repeat (9) @(negedge clk);
    chk("flush_busy_before", busy, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_idle", in_ready, 1'b1);
    chk("flush_not_busy", busy, 1'b0);
    begin
      int seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("flush_no_out_valid", seen, 0);
    end

    // asynchronous reset in the middle of a divide
    issue(3'd4, 32'd1000, 32'd3, 5'd14);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_out_result", out_result, 32'h0);
    chk("arst_out_tag", out_tag, 5'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    directed("after_reset", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, MulLat);

    // randomized traffic with random backpressure and occasional flush
    rand_en = 1;
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom_range(0, 31)));
    end
    @(negedge clk);
    rand_en   = 0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    chk("final_idle", in_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
